// File: rtl/cnn_img_pkg.sv
// Shared image constants, background pixel value and loader state encoding
// used by the test-image ROM, the frame loader and the conv front end.
package cnn_img_pkg;
   localparam int IMG_W      = 28;
   localparam int IMG_H      = 28;
   localparam int IMG_PIXELS = IMG_W * IMG_H;
   localparam int ADDR_W     = 10;

   localparam logic signed [7:0] PIX_BG = 8'sh80;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_LOADING,
      ST_FULL
   } state_t;

   // Unsigned 0..255 to signed -128..127; flipping the MSB equals subtracting 128.
   function automatic logic [7:0] to_signed_pix(input logic [7:0] raw);
      return raw ^ 8'h80;
   endfunction
endpackage

// File: rtl/image_ram.sv
// Simple dual-port image buffer: one synchronous write port and one
// synchronous read-first read port.
module image_ram #(
   parameter int DEPTH  = 784,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_q
);
   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_q <= mem[rd_addr];
   end
endmodule

// File: rtl/image_frame_loader.sv
// Streams an 8-bit grayscale frame into the image buffer as signed pixels and
// serves it through a ROM-compatible registered read port.
module image_frame_loader
   import cnn_img_pkg::*;
#(
   parameter int IMG_W  = cnn_img_pkg::IMG_W,
   parameter int IMG_H  = cnn_img_pkg::IMG_H,
   parameter int ADDR_W = cnn_img_pkg::ADDR_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [7:0]               in_data,
   input  logic                     in_sof,
   output logic                     frame_valid,
   input  logic                     frame_release,
   output logic                     sof_err,
   output logic [ADDR_W-1:0]        pixel_count,
   input  logic [ADDR_W-1:0]        rd_addr,
   output logic signed [7:0]        rd_data
);
   localparam int                N     = IMG_W * IMG_H;
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(N - 1);
   localparam logic [ADDR_W:0]   LIMIT = (ADDR_W + 1)'(N);

   state_t            state, state_next;
   logic [ADDR_W-1:0] count, count_next;
   logic              accept;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic              sof_hit;
   logic              rd_oob;
   logic [7:0]        ram_q;

   // Handshake: a beat transfers on a rising edge where in_valid && in_ready.
   assign in_ready    = (state != ST_FULL) && !rst;
   assign accept      = in_valid && in_ready;
   assign frame_valid = (state == ST_FULL);
   assign pixel_count = count;

   always_comb begin
      state_next = state;
      count_next = count;
      wr_en      = 1'b0;
      wr_addr    = count;
      sof_hit    = 1'b0;
      case (state)
         ST_EMPTY, ST_LOADING: begin
            if (accept) begin
               wr_en = 1'b1;
               if (in_sof && (count != '0)) begin
                  // Mid-frame SOF restarts the frame at pixel 0.
                  sof_hit    = 1'b1;
                  wr_addr    = '0;
                  count_next = ADDR_W'(1);
                  state_next = ST_LOADING;
               end else if (count == LAST) begin
                  count_next = '0;
                  state_next = ST_FULL;
               end else begin
                  count_next = count + 1'b1;
                  state_next = ST_LOADING;
               end
            end
         end
         ST_FULL: begin
            if (frame_release) begin
               state_next = ST_EMPTY;
            end
         end
         default: state_next = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_EMPTY;
         count   <= '0;
         sof_err <= 1'b0;
         rd_oob  <= 1'b1;
      end else begin
         state   <= state_next;
         count   <= count_next;
         sof_err <= sof_hit;
         rd_oob  <= ({1'b0, rd_addr} >= LIMIT);
      end
   end

   image_ram #(
      .DEPTH  (N),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (to_signed_pix(in_data)),
      .rd_addr (rd_addr),
      .rd_q    (ram_q)
   );

   // Out-of-range (and post-reset) reads return the background pixel.
   assign rd_data = rd_oob ? PIX_BG : $signed(ram_q);
endmodule

// File: tb/tb_image_frame_loader.sv
// Directed bench for image_frame_loader: frame model plus literal pins.
module tb_image_frame_loader;
  import cnn_img_pkg::*;

  localparam int N = 784;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              in_sof;
  logic              frame_valid;
  logic              frame_release;
  logic              sof_err;
  logic [9:0]        pixel_count;
  logic [9:0]        rd_addr;
  logic signed [7:0] rd_data;

  int n_checks = 0;
  int n_pass   = 0;

  image_frame_loader dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_sof        (in_sof),
    .frame_valid   (frame_valid),
    .frame_release (frame_release),
    .sof_err       (sof_err),
    .pixel_count   (pixel_count),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  int m_mem   [N];
  bit m_known [N];
  bit m_full;
  int m_count;
  bit m_sof_err;
  int m_rd;
  bit m_rd_known;
  bit chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_full     = 1'b0;
      m_count    = 0;
      m_sof_err  = 1'b0;
      m_rd       = -128;
      m_rd_known = 1'b1;
      chk_en     = 1'b1;
    end else begin
      if (int'(rd_addr) >= N) begin
        m_rd = -128; m_rd_known = 1'b1;
      end else begin
        m_rd = m_mem[rd_addr]; m_rd_known = m_known[rd_addr];
      end
      m_sof_err = 1'b0;
      if (!m_full && in_valid) begin
        if (in_sof && m_count != 0) begin
          m_sof_err = 1'b1;
          m_mem[0] = int'(in_data) - 128; m_known[0] = 1'b1;
          m_count = 1;
        end else begin
          m_mem[m_count] = int'(in_data) - 128; m_known[m_count] = 1'b1;
          m_count++;
          if (m_count == N) begin
            m_full = 1'b1; m_count = 0;
          end
        end
      end else if (m_full && frame_release) begin
        m_full = 1'b0;
      end
    end
  end

  // Compare process: outputs are stable mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", in_ready, !m_full && !rst);
      check("frame_valid", frame_valid, m_full);
      check("pixel_count", pixel_count, m_count);
      check("sof_err", sof_err, m_sof_err);
      if (m_rd_known) check("rd_data", rd_data, m_rd);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic sof);
    bit acc;
    int guard;
    in_valid = 1'b1; in_data = d; in_sof = sof;
    acc = 1'b0; guard = 0;
    while (!acc && guard < 100) begin
      acc = in_ready;
      tick();
      guard++;
    end
    if (!acc) check("beat_timeout", 0, 1);
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic read_px(input int a, output logic signed [7:0] v);
    rd_addr = 10'(a);
    tick();
    v = rd_data;
  endtask

  function automatic bit is_stroke(input int a);
    int r, c;
    r = a / 28; c = a % 28;
    return (r == 5 && c >= 12 && c <= 17) || (r >= 6 && r <= 22 && c == 17 - (r - 6) / 3);
  endfunction

  // ---------------- stimulus ----------------
  logic [7:0] exp_q[$];
  logic signed [7:0] v;
  int vals [6] = '{0, 1, 127, 128, 200, 255};
  int exps [6] = '{-128, -127, -1, 0, 72, 127};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sof = 1'b0;
    frame_release = 1'b0; rd_addr = '0;
    repeat (3) tick();
    check("rst_count", pixel_count, 0);
    check("rst_fv", frame_valid, 0);
    check("rst_rd", rd_data, -128);
    check("rst_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", in_ready, 1);

    // Digit-7 frame at full rate.
    for (int a = 0; a < N; a++) begin
      if (a == N - 1) check("fv_before_last", frame_valid, 0);
      send_beat(is_stroke(a) ? 8'd255 : 8'd0, a == 0);
    end
    check("fv_after_last", frame_valid, 1);
    in_valid = 1'b1; in_data = 8'h55;
    repeat (5) begin
      tick();
      check("full_ready", in_ready, 0);
      check("full_count", pixel_count, 0);
    end
    in_valid = 1'b0;
    for (int a = 0; a < N; a++) begin
      read_px(a, v);
      check("img7", v, is_stroke(a) ? 127 : -128);
    end
    frame_release = 1'b1;
    tick();
    frame_release = 1'b0;
    check("rel_fv", frame_valid, 0);
    check("rel_ready", in_ready, 1);

    // Conversion corners at addr 0..5.
    for (int i = 0; i < 6; i++) send_beat(8'(vals[i]), i == 0);
    check("count6", pixel_count, 6);
    for (int i = 0; i < 6; i++) begin
      read_px(i, v);
      check("conv", v, exps[i]);
    end

    // Mid-frame SOF after 300 beats, with a same-address read-first probe.
    for (int i = 6; i < 300; i++) send_beat(8'($urandom_range(0, 255)), 1'b0);
    check("count300", pixel_count, 300);
    rd_addr = '0;
    send_beat(8'd255, 1'b1);
    check("sof_pulse", sof_err, 1);
    check("read_first", rd_data, -128);
    tick();
    check("sof_once", sof_err, 0);
    check("sof_count", pixel_count, 1);
    check("sof_addr0", rd_data, 127);
    for (int i = 1; i < N - 1; i++) send_beat(8'($urandom_range(0, 255)), 1'b0);
    check("fv_783", frame_valid, 0);
    send_beat(8'd9, 1'b0);
    check("fv_after_sof", frame_valid, 1);
    frame_release = 1'b1;
    tick();
    frame_release = 1'b0;

    // Reset mid-load.
    for (int i = 0; i < 500; i++) send_beat(8'($urandom_range(0, 255)), 1'b0);
    rst = 1'b1;
    tick();
    check("mid_rst_count", pixel_count, 0);
    check("mid_rst_fv", frame_valid, 0);
    check("mid_rst_rd", rd_data, -128);
    rst = 1'b0;
    tick();

    // Gappy stream, scoreboarded against the buffer.
    for (int i = 0; i < N; i++) begin
      logic [7:0] d;
      repeat ($urandom_range(0, 1)) tick();
      d = 8'($urandom_range(0, 255));
      exp_q.push_back(d);
      send_beat(d, 1'b0);
    end
    check("gap_fv", frame_valid, 1);
    for (int a = 0; a < N; a++) begin
      logic [7:0] d;
      d = exp_q.pop_front();
      read_px(a, v);
      check("gap_buf", v, int'(d) - 128);
    end
    read_px(784, v);
    check("oob_784", v, -128);
    read_px(1023, v);
    check("oob_1023", v, -128);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
